// File: rtl/operand_fetch_pkg.sv
// Shared widths, register-file geometry and the opcode set used by decode,
// operand fetch and the ALU.
package operand_fetch_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int OP_W   = 5;
   localparam int CNT_W  = 2;
   localparam int NREG   = 1 << ADDR_W;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam cnt_t CNT_MAX = '1;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 5'd0,
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SHL,
      OP_SHR
   } opcode_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Issue, register-file read, writeback and ALU-side bundle of the operand
// fetch stage; slave is the stage itself, master is its environment.
interface operand_fetch_if;
   import operand_fetch_pkg::*;

   logic      in_valid;
   logic      in_ready;
   opcode_e   in_op;
   reg_addr_t in_src1;
   reg_addr_t in_src2;
   reg_addr_t in_dst;
   logic      in_wr;

   reg_addr_t rf_rd_addr1;
   reg_addr_t rf_rd_addr2;
   data_t     rf_rd_data1;
   data_t     rf_rd_data2;

   logic      wb_en;
   reg_addr_t wb_addr;
   data_t     wb_data;

   logic      out_valid;
   logic      out_ready;
   opcode_e   out_op;
   reg_addr_t out_dst;
   logic      out_wr;
   data_t     out_a;
   data_t     out_b;
   logic      sb_err;

   modport slave (
      input  in_valid, in_op, in_src1, in_src2, in_dst, in_wr,
      output in_ready,
      output rf_rd_addr1, rf_rd_addr2,
      input  rf_rd_data1, rf_rd_data2,
      input  wb_en, wb_addr, wb_data,
      output out_valid, out_op, out_dst, out_wr, out_a, out_b, sb_err,
      input  out_ready
   );

   modport master (
      output in_valid, in_op, in_src1, in_src2, in_dst, in_wr,
      input  in_ready,
      input  rf_rd_addr1, rf_rd_addr2,
      output rf_rd_data1, rf_rd_data2,
      output wb_en, wb_addr, wb_data,
      input  out_valid, out_op, out_dst, out_wr, out_a, out_b, sb_err,
      output out_ready
   );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Per-register count of issued-but-unretired writes; flags source hazards,
// counter saturation and writebacks that arrive with nothing outstanding.
module reg_scoreboard
   import operand_fetch_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  reg_addr_t src1,
   input  reg_addr_t src2,
   input  reg_addr_t dst,
   input  logic      wr,
   input  logic      issue,
   input  logic      wb_en,
   input  reg_addr_t wb_addr,
   output logic      busy1,
   output logic      busy2,
   output logic      sat,
   output logic      sb_err
);

   cnt_t cnt [NREG];
   logic alloc;

   // A single outstanding write is harmless when it retires this very cycle.
   function automatic logic src_busy(cnt_t c, logic wb_hit);
      return (c > cnt_t'(1)) || ((c == cnt_t'(1)) && !wb_hit);
   endfunction

   function automatic cnt_t cnt_next(cnt_t c, logic inc, logic dec);
      case ({inc, dec})
         2'b10:   return (c == CNT_MAX) ? c : c + cnt_t'(1);
         2'b01:   return (c == '0) ? c : c - cnt_t'(1);
         default: return c;
      endcase
   endfunction

   assign alloc = issue && wr;
   assign busy1 = src_busy(cnt[src1], wb_en && (wb_addr == src1));
   assign busy2 = src_busy(cnt[src2], wb_en && (wb_addr == src2));
   assign sat   = wr && (cnt[dst] == CNT_MAX) && !(wb_en && (wb_addr == dst));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++)
            cnt[r] <= cnt_next(cnt[r], alloc && (dst == reg_addr_t'(r)),
                               wb_en && (wb_addr == reg_addr_t'(r)));
         if (wb_en && (cnt[wb_addr] == '0) && !(alloc && (dst == wb_addr)))
            sb_err <= 1'b1;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read with writeback forwarding, scoreboard
// hazard stall and a single output register feeding the ALU.
module operand_fetch
   import operand_fetch_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   operand_fetch_if.slave bus
);

   logic      busy1, busy2, sat, sb_err;
   logic      ready, fire;
   data_t     opa_p0, opb_p0;

   logic      vld_p1;
   opcode_e   op_p1;
   reg_addr_t dst_p1;
   logic      wr_p1;
   data_t     a_p1, b_p1;

   // The file commits a writeback one cycle late, so same-cycle wb data wins.
   function automatic data_t fwd_sel(reg_addr_t src, data_t rf_data,
                                     logic wb_en, reg_addr_t wb_addr,
                                     data_t wb_data);
      return (wb_en && (wb_addr == src)) ? wb_data : rf_data;
   endfunction

   assign bus.rf_rd_addr1 = bus.in_src1;
   assign bus.rf_rd_addr2 = bus.in_src2;

   assign opa_p0 = fwd_sel(bus.in_src1, bus.rf_rd_data1, bus.wb_en, bus.wb_addr, bus.wb_data);
   assign opb_p0 = fwd_sel(bus.in_src2, bus.rf_rd_data2, bus.wb_en, bus.wb_addr, bus.wb_data);

   assign ready = (!vld_p1 || bus.out_ready) && !busy1 && !busy2 && !sat;
   assign fire  = bus.in_valid && ready;

   reg_scoreboard u_sb (
      .clk     (clk),
      .reset   (reset),
      .src1    (bus.in_src1),
      .src2    (bus.in_src2),
      .dst     (bus.in_dst),
      .wr      (bus.in_wr),
      .issue   (fire),
      .wb_en   (bus.wb_en),
      .wb_addr (bus.wb_addr),
      .busy1   (busy1),
      .busy2   (busy2),
      .sat     (sat),
      .sb_err  (sb_err)
   );

   // p0 -> p1: operand bundle register toward the ALU
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         op_p1  <= OP_NOP;
         dst_p1 <= '0;
         wr_p1  <= 1'b0;
         a_p1   <= '0;
         b_p1   <= '0;
      end else if (fire) begin
         vld_p1 <= 1'b1;
         op_p1  <= bus.in_op;
         dst_p1 <= bus.in_dst;
         wr_p1  <= bus.in_wr;
         a_p1   <= opa_p0;
         b_p1   <= opb_p0;
      end else if (bus.out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = vld_p1;
   assign bus.out_op    = op_p1;
   assign bus.out_dst   = dst_p1;
   assign bus.out_wr    = wr_p1;
   assign bus.out_a     = a_p1;
   assign bus.out_b     = b_p1;
   assign bus.sb_err    = sb_err;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding, RAW stall, output hold,
// scoreboard saturation, sb_err and asynchronous reset.
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   data_t rf [NREG];

   operand_fetch_if bus ();

   operand_fetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Register file environment: combinational read, write on the clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) rf[r] <= '0;
      end else if (bus.wb_en) begin
         rf[bus.wb_addr] <= bus.wb_data;
      end
   end
   assign bus.rf_rd_data1 = rf[bus.rf_rd_addr1];
   assign bus.rf_rd_data2 = rf[bus.rf_rd_addr2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic v, input opcode_e op, input int s1, input int s2,
                      input int d, input logic w);
      bus.in_valid = v;
      bus.in_op    = op;
      bus.in_src1  = reg_addr_t'(s1);
      bus.in_src2  = reg_addr_t'(s2);
      bus.in_dst   = reg_addr_t'(d);
      bus.in_wr    = w;
   endtask

   task automatic wbk(input logic en, input int a, input int dat);
      bus.wb_en   = en;
      bus.wb_addr = reg_addr_t'(a);
      bus.wb_data = data_t'(dat);
   endtask

   task automatic edge_after();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      put(1'b0, OP_NOP, 0, 0, 0, 1'b0);
      wbk(1'b0, 0, 0);
      bus.out_ready = 1'b1;
      edge_after();
      edge_after();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_a", bus.out_a, 0);
      check("rst_out_b", bus.out_b, 0);
      check("rst_out_op", bus.out_op, 0);
      check("rst_out_dst", bus.out_dst, 0);
      check("rst_out_wr", bus.out_wr, 0);
      check("rst_sb_err", bus.sb_err, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      reset = 1'b1;

      // Allocate R3, then retire it with 0x5A while issuing ADD R3,R3 (forwarded)
      @(negedge clk);
      put(1'b1, OP_NOP, 0, 0, 3, 1'b1);
      #1 check("alloc_r3_ready", bus.in_ready, 1);
      edge_after();
      check("alloc_r3_valid", bus.out_valid, 1);
      check("alloc_r3_wr", bus.out_wr, 1);
      check("alloc_r3_dst", bus.out_dst, 3);
      @(negedge clk);
      put(1'b1, OP_ADD, 3, 3, 4, 1'b0);
      wbk(1'b1, 3, 8'h5A);
      #1 check("fwd_ready", bus.in_ready, 1);
      check("rf_addr1", bus.rf_rd_addr1, 3);
      edge_after();
      check("fwd_out_valid", bus.out_valid, 1);
      check("fwd_out_a", bus.out_a, 8'h5A);
      check("fwd_out_b", bus.out_b, 8'h5A);
      check("fwd_out_op", bus.out_op, OP_ADD);
      check("fwd_out_dst", bus.out_dst, 4);

      // Plain register-file read path
      @(negedge clk);
      put(1'b1, OP_SUB, 3, 1, 5, 1'b0);
      wbk(1'b0, 0, 0);
      edge_after();
      check("rf_out_a", bus.out_a, 8'h5A);
      check("rf_out_b", bus.out_b, 0);
      check("rf_out_op", bus.out_op, OP_SUB);

      // RAW stall on R2 until its writeback, then zero-bubble forward
      @(negedge clk);
      put(1'b1, OP_OR, 0, 0, 2, 1'b1);
      edge_after();
      @(negedge clk);
      put(1'b1, OP_AND, 2, 3, 6, 1'b0);
      #1 check("raw_stall0", bus.in_ready, 0);
      edge_after();
      check("raw_drain_valid", bus.out_valid, 0);
      @(negedge clk);
      #1 check("raw_stall1", bus.in_ready, 0);
      edge_after();
      @(negedge clk);
      wbk(1'b1, 2, 8'h11);
      #1 check("raw_release", bus.in_ready, 1);
      edge_after();
      check("raw_out_valid", bus.out_valid, 1);
      check("raw_out_a", bus.out_a, 8'h11);
      check("raw_out_b", bus.out_b, 8'h5A);

      // Produce out_a=0x22 via R7, then stall the output for 4 cycles
      @(negedge clk);
      wbk(1'b0, 0, 0);
      put(1'b1, OP_NOP, 0, 0, 7, 1'b1);
      edge_after();
      @(negedge clk);
      put(1'b1, OP_XOR, 7, 2, 1, 1'b1);
      wbk(1'b1, 7, 8'h22);
      edge_after();
      check("hold_pre_a", bus.out_a, 8'h22);
      check("hold_pre_b", bus.out_b, 8'h11);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wbk(1'b0, 0, 0);
         put(1'b1, OP_SUB, 3, 2, 0, 1'b0);
         bus.out_ready = 1'b0;
         #1 check("hold_in_ready", bus.in_ready, 0);
         edge_after();
         check("hold_valid", bus.out_valid, 1);
         check("hold_a", bus.out_a, 8'h22);
         check("hold_b", bus.out_b, 8'h11);
         check("hold_op", bus.out_op, OP_XOR);
         check("hold_dst", bus.out_dst, 1);
         check("hold_wr", bus.out_wr, 1);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1 check("hold_release_ready", bus.in_ready, 1);
      edge_after();
      check("next_valid", bus.out_valid, 1);
      check("next_op", bus.out_op, OP_SUB);
      check("next_a", bus.out_a, 8'h5A);
      check("next_b", bus.out_b, 8'h11);
      check("next_wr", bus.out_wr, 0);

      // Three writes to R5 saturate the 2-bit counter
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         put(1'b1, OP_NOP, 0, 0, 5, 1'b1);
         #1 check("sat_fill_ready", bus.in_ready, 1);
         edge_after();
      end
      @(negedge clk);
      #1 check("sat_stall", bus.in_ready, 0);
      edge_after();
      check("sat_drain_valid", bus.out_valid, 0);
      @(negedge clk);
      wbk(1'b1, 5, 8'h33);
      #1 check("sat_wb_ready", bus.in_ready, 1);
      edge_after();
      check("sat_wb_fire", bus.out_valid, 1);
      @(negedge clk);
      wbk(1'b0, 0, 0);
      #1 check("sat_still_3", bus.in_ready, 0);
      edge_after();
      // Drain R5 (3 -> 2 -> 1) while a reader waits, then forward on the last
      @(negedge clk);
      put(1'b1, OP_ADD, 5, 0, 0, 1'b0);
      wbk(1'b1, 5, 8'h33);
      #1 check("cnt3_busy", bus.in_ready, 0);
      edge_after();
      @(negedge clk);
      #1 check("cnt2_busy", bus.in_ready, 0);
      edge_after();
      @(negedge clk);
      wbk(1'b1, 5, 8'h44);
      #1 check("cnt1_wb_ready", bus.in_ready, 1);
      edge_after();
      check("cnt1_out_a", bus.out_a, 8'h44);
      check("cnt1_out_b", bus.out_b, 0);

      // Writeback to idle R6 sets the sticky error without underflow
      @(negedge clk);
      put(1'b0, OP_NOP, 6, 6, 0, 1'b0);
      wbk(1'b1, 6, 8'h66);
      #1 check("err_before", bus.sb_err, 0);
      edge_after();
      check("err_set", bus.sb_err, 1);
      @(negedge clk);
      wbk(1'b0, 0, 0);
      #1 check("err_no_underflow", bus.in_ready, 1);
      edge_after();
      edge_after();
      check("err_sticky", bus.sb_err, 1);

      // Second write to R1 (cnt 2), then asynchronous reset mid-flight
      @(negedge clk);
      put(1'b1, OP_NOP, 3, 0, 1, 1'b1);
      edge_after();
      check("pre_rst_valid", bus.out_valid, 1);
      check("pre_rst_a", bus.out_a, 8'h5A);
      @(negedge clk);
      put(1'b0, OP_NOP, 1, 1, 0, 1'b0);
      #1 check("pre_rst_r1_busy", bus.in_ready, 0);
      #1 reset = 1'b0;
      #1;
      check("async_valid", bus.out_valid, 0);
      check("async_a", bus.out_a, 0);
      check("async_dst", bus.out_dst, 0);
      check("async_wr", bus.out_wr, 0);
      check("async_sb_err", bus.sb_err, 0);
      check("async_cnt_clear", bus.in_ready, 1);
      @(negedge clk);
      reset = 1'b1;
      edge_after();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
